// File: rtl/instr_stream_if.sv
// Fetch/push handshake bundle between an instruction source and the stream responder.
// The responder connects through the slave modport.
interface instr_stream_if;
   logic        push_valid_i;
   logic [31:0] push_data_i;
   logic        push_ready_o;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;

   modport master (
      output push_valid_i, push_data_i, instr_req_i, instr_addr_i,
      input  push_ready_o, instr_gnt_o, instr_rvalid_o, instr_rdata_o
   );

   modport slave (
      input  push_valid_i, push_data_i, instr_req_i, instr_addr_i,
      output push_ready_o, instr_gnt_o, instr_rvalid_o, instr_rdata_o
   );
endinterface

// File: rtl/instr_stream_responder.sv
// Instruction-fetch responder: serves core fetches from a pushed instruction FIFO,
// optionally filling with a NOP when starved.
//
// state   | meaning
// IDLE    | service disabled, no grants
// RUN     | granting fetches from FIFO (or NOP fill)
// STARVED | FIFO empty with NOP fill off; waiting for a push
module instr_stream_responder #(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter bit          FILL_NOP  = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                flush_i,
   instr_stream_if.slave       bus,
   output logic [1:0]          state_o,
   output logic [15:0]         fetch_cnt_o,
   output logic [15:0]         nop_cnt_o,
   output logic [31:0]         last_addr_o,
   output logic                misalign_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      STARVED = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q;
   logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
   logic [31:0]    mem_q [DEPTH];
   logic           push, pop, gnt, fifo_nempty;

   assign fifo_nempty      = (count_q != '0);
   assign bus.push_ready_o = (count_q < DEPTH_C);
   assign push             = bus.push_valid_i && bus.push_ready_o;
   // Grant only looks at the count from the start of the cycle, so a push into
   // an empty FIFO is never bypassed to the core in the same cycle.
   assign gnt              = !rst_i && bus.instr_req_i && (state_q == RUN)
                             && (fifo_nempty || FILL_NOP);
   assign pop              = gnt && fifo_nempty;
   assign bus.instr_gnt_o  = gnt;
   assign state_o          = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en_i) state_d = RUN;
         RUN: begin
            if (!en_i)                                           state_d = IDLE;
            else if (!FILL_NOP && !fifo_nempty && bus.instr_req_i) state_d = STARVED;
         end
         STARVED: begin
            if (!en_i)            state_d = IDLE;
            else if (fifo_nempty) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q            <= IDLE;
         count_q            <= '0;
         rd_ptr_q           <= '0;
         wr_ptr_q           <= '0;
         bus.instr_rvalid_o <= 1'b0;
         bus.instr_rdata_o  <= '0;
         fetch_cnt_o        <= '0;
         nop_cnt_o          <= '0;
         last_addr_o        <= '0;
         misalign_o         <= 1'b0;
      end else begin
         state_q            <= state_d;
         bus.instr_rvalid_o <= gnt;

         if (flush_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            count_q <= count_q + (push ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         end

         if (gnt) begin
            bus.instr_rdata_o <= pop ? mem_q[rd_ptr_q] : NOP_INSTR;
            fetch_cnt_o       <= fetch_cnt_o + 16'd1;
            last_addr_o       <= bus.instr_addr_i;
            if (bus.instr_addr_i[1:0] != 2'b00) misalign_o <= 1'b1;
            if (!pop && nop_cnt_o != 16'hFFFF) nop_cnt_o <= nop_cnt_o + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !flush_i) mem_q[wr_ptr_q] <= bus.push_data_i;
   end

endmodule

// File: tb/tb_instr_stream_responder.sv
// Directed bench for instr_stream_responder: a per-cycle vector table plus
// hand sequences for fill/wrap, no-fill starvation and mid-stream reset.
module tb_instr_stream_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, flush;
   logic [1:0]  state, state_nf;
   logic [15:0] fc, nc, fc_nf, nc_nf;
   logic [31:0] last, last_nf;
   logic        mis, mis_nf;

   instr_stream_if bus();
   instr_stream_if bus_nf();

   instr_stream_responder #(.DEPTH(8), .NOP_INSTR(32'h0000_0013), .FILL_NOP(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .bus(bus),
      .state_o(state), .fetch_cnt_o(fc), .nop_cnt_o(nc),
      .last_addr_o(last), .misalign_o(mis)
   );

   instr_stream_responder #(.DEPTH(8), .NOP_INSTR(32'h0000_0013), .FILL_NOP(1'b0)) dut_nf (
      .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .bus(bus_nf),
      .state_o(state_nf), .fetch_cnt_o(fc_nf), .nop_cnt_o(nc_nf),
      .last_addr_o(last_nf), .misalign_o(mis_nf)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic e, input logic f, input logic pv, input logic [31:0] pd,
                         input logic rq, input logic [31:0] ad);
      en = e;
      flush = f;
      bus.push_valid_i = pv;
      bus.push_data_i  = pd;
      bus.instr_req_i  = rq;
      bus.instr_addr_i = ad;
   endtask

   typedef struct {
      logic        en, flush, pv;
      logic [31:0] pd;
      logic        req;
      logic [31:0] addr;
      logic        gnt, rv;
      logic [31:0] rdata;
      logic [1:0]  st;
      logic [15:0] fc, nc;
      logic [31:0] last;
      logic        mis;
   } vec_t;

   function automatic vec_t v(logic e, logic f, logic pv, logic [31:0] pd, logic rq,
                              logic [31:0] ad, logic g, logic rv, logic [31:0] rd,
                              logic [1:0] st, logic [15:0] fcx, logic [15:0] ncx,
                              logic [31:0] la, logic ms);
      vec_t r;
      r.en = e; r.flush = f; r.pv = pv; r.pd = pd; r.req = rq; r.addr = ad;
      r.gnt = g; r.rv = rv; r.rdata = rd; r.st = st; r.fc = fcx; r.nc = ncx;
      r.last = la; r.mis = ms;
      return r;
   endfunction

   vec_t tbl[25];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;

      //   en fl pv data          rq addr    | gnt rv rdata          st fc  nc  last     mis
      tbl[0]  = v(1,0,0,0,            0,0,        0,0,0,             1,0, 0, 0,       0);
      tbl[1]  = v(1,0,1,32'h00500093, 0,0,        0,0,0,             1,0, 0, 0,       0);
      tbl[2]  = v(1,0,1,32'h00A00113, 0,0,        0,0,0,             1,0, 0, 0,       0);
      tbl[3]  = v(1,0,0,0,            1,0,        1,1,32'h00500093,  1,1, 0, 0,       0);
      tbl[4]  = v(1,0,0,0,            1,4,        1,1,32'h00A00113,  1,2, 0, 4,       0);
      tbl[5]  = v(1,0,0,0,            0,0,        0,0,32'h00A00113,  1,2, 0, 4,       0);
      tbl[6]  = v(1,0,0,0,            1,8,        1,1,NOP,           1,3, 1, 8,       0);
      tbl[7]  = v(1,0,0,0,            1,12,       1,1,NOP,           1,4, 2, 12,      0);
      tbl[8]  = v(1,0,0,0,            1,16,       1,1,NOP,           1,5, 3, 16,      0);
      tbl[9]  = v(1,0,0,0,            0,0,        0,0,NOP,           1,5, 3, 16,      0);
      tbl[10] = v(1,0,1,32'h11111111, 0,0,        0,0,NOP,           1,5, 3, 16,      0);
      tbl[11] = v(1,0,1,32'h22222222, 0,0,        0,0,NOP,           1,5, 3, 16,      0);
      tbl[12] = v(1,0,1,32'h33333333, 0,0,        0,0,NOP,           1,5, 3, 16,      0);
      tbl[13] = v(1,1,1,32'h44444444, 0,0,        0,0,NOP,           1,5, 3, 16,      0);
      tbl[14] = v(1,0,0,0,            1,2,        1,1,NOP,           1,6, 4, 2,       1);
      tbl[15] = v(1,0,0,0,            1,32'h20,   1,1,NOP,           1,7, 5, 32'h20,  1);
      tbl[16] = v(1,0,0,0,            0,0,        0,0,NOP,           1,7, 5, 32'h20,  1);
      tbl[17] = v(1,0,1,32'hAAAA0001, 1,32'h24,   1,1,NOP,           1,8, 6, 32'h24,  1);
      tbl[18] = v(1,0,1,32'hBBBB0002, 1,32'h28,   1,1,32'hAAAA0001,  1,9, 6, 32'h28,  1);
      tbl[19] = v(1,0,0,0,            1,32'h2C,   1,1,32'hBBBB0002,  1,10,6, 32'h2C,  1);
      tbl[20] = v(0,0,0,0,            0,0,        0,0,32'hBBBB0002,  0,10,6, 32'h2C,  1);
      tbl[21] = v(0,0,0,0,            1,32'h30,   0,0,32'hBBBB0002,  0,10,6, 32'h2C,  1);
      tbl[22] = v(1,0,0,0,            0,0,        0,0,32'hBBBB0002,  1,10,6, 32'h2C,  1);
      tbl[23] = v(0,0,0,0,            1,32'h34,   1,1,NOP,           0,11,7, 32'h34,  1);
      tbl[24] = v(0,0,0,0,            0,0,        0,0,NOP,           0,11,7, 32'h34,  1);

      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      bus_nf.push_valid_i = 1'b0;
      bus_nf.push_data_i  = '0;
      bus_nf.instr_req_i  = 1'b0;
      bus_nf.instr_addr_i = '0;
      repeat (3) @(posedge clk);
      #1;

      chk("rst rvalid",   bus.instr_rvalid_o, 0);
      chk("rst rdata",    bus.instr_rdata_o, 0);
      chk("rst state",    state, 0);
      chk("rst fetch",    fc, 0);
      chk("rst nop",      nc, 0);
      chk("rst last",     last, 0);
      chk("rst mis",      mis, 0);
      chk("rst ready",    bus.push_ready_o, 1);
      chk("rst nf state", state_nf, 0);
      rst = 1'b0;

      for (int i = 0; i < 25; i++) begin
         set_in(tbl[i].en, tbl[i].flush, tbl[i].pv, tbl[i].pd, tbl[i].req, tbl[i].addr);
         #1;
         chk($sformatf("v%0d gnt", i), bus.instr_gnt_o, tbl[i].gnt);
         chk($sformatf("v%0d ready", i), bus.push_ready_o, 1);
         tick();
         chk($sformatf("v%0d rvalid", i), bus.instr_rvalid_o, tbl[i].rv);
         chk($sformatf("v%0d rdata", i),  bus.instr_rdata_o, tbl[i].rdata);
         chk($sformatf("v%0d state", i),  state, tbl[i].st);
         chk($sformatf("v%0d fetch", i),  fc, tbl[i].fc);
         chk($sformatf("v%0d nop", i),    nc, tbl[i].nc);
         chk($sformatf("v%0d last", i),   last, tbl[i].last);
         chk($sformatf("v%0d mis", i),    mis, tbl[i].mis);
      end

      // Fill to full (pointers start mid-array so they wrap), overflow push, drain.
      set_in(1, 0, 0, 0, 0, 0);
      tick();
      for (int k = 0; k < 8; k++) begin
         set_in(1, 0, 1, 32'hC000_0000 + k, 0, 0);
         #1;
         chk($sformatf("fill%0d ready", k), bus.push_ready_o, 1);
         tick();
      end
      set_in(1, 0, 1, 32'hDEAD_BEEF, 0, 0);
      #1;
      chk("full ready", bus.push_ready_o, 0);
      tick();
      for (int k = 0; k < 8; k++) begin
         set_in(1, 0, 0, 0, 1, 32'(k * 4));
         #1;
         chk($sformatf("drain%0d gnt", k), bus.instr_gnt_o, 1);
         tick();
         chk($sformatf("drain%0d rvalid", k), bus.instr_rvalid_o, 1);
         chk($sformatf("drain%0d rdata", k), bus.instr_rdata_o, 32'hC000_0000 + k);
      end
      set_in(1, 0, 0, 0, 1, 0);
      #1;
      chk("empty ready", bus.push_ready_o, 1);
      tick();
      chk("overflow dropped", bus.instr_rdata_o, NOP);

      // Streaming push and pop in the same cycles across the pointer wrap.
      for (int j = 0; j < 8; j++) begin
         set_in(1, 0, 1, 32'hD000_0000 + j, (j > 0), 0);
         #1;
         chk($sformatf("stream%0d gnt", j), bus.instr_gnt_o, (j > 0));
         tick();
         chk($sformatf("stream%0d rvalid", j), bus.instr_rvalid_o, (j > 0));
         if (j > 0) chk($sformatf("stream%0d rdata", j), bus.instr_rdata_o, 32'hD000_0000 + j - 1);
      end
      set_in(1, 0, 0, 0, 1, 0);
      tick();
      chk("stream last rdata", bus.instr_rdata_o, 32'hD000_0007);
      set_in(1, 0, 0, 0, 0, 0);
      tick();

      // No-fill starvation on the second instance.
      chk("nf state run", state_nf, 1);
      bus_nf.instr_req_i  = 1'b1;
      bus_nf.instr_addr_i = 32'h40;
      #1;
      chk("nf empty gnt", bus_nf.instr_gnt_o, 0);
      tick();
      chk("nf starved", state_nf, 2);
      bus_nf.push_valid_i = 1'b1;
      bus_nf.push_data_i  = 32'h0000_0033;
      #1;
      chk("nf push gnt", bus_nf.instr_gnt_o, 0);
      tick();
      bus_nf.push_valid_i = 1'b0;
      w = 0;
      while (state_nf !== 2'd1 && w < 4) begin
         tick();
         w++;
      end
      chk("nf back to run", state_nf, 1);
      chk("nf resume gnt", bus_nf.instr_gnt_o, 1);
      tick();
      bus_nf.instr_req_i = 1'b0;
      chk("nf rvalid", bus_nf.instr_rvalid_o, 1);
      chk("nf rdata", bus_nf.instr_rdata_o, 32'h0000_0033);
      chk("nf fetch", fc_nf, 1);
      chk("nf nop", nc_nf, 0);

      // Reset right after a grant, with a word still queued.
      set_in(1, 0, 1, 32'h5555_0001, 0, 0);
      tick();
      set_in(1, 0, 1, 32'h5555_0002, 0, 0);
      tick();
      set_in(1, 0, 0, 0, 1, 32'h100);
      #1;
      chk("pre-rst gnt", bus.instr_gnt_o, 1);
      tick();
      chk("pre-rst rdata", bus.instr_rdata_o, 32'h5555_0001);
      rst = 1'b1;
      set_in(1, 0, 0, 0, 1, 32'h104);
      #1;
      chk("gnt in rst", bus.instr_gnt_o, 0);
      tick();
      chk("mid-rst rvalid", bus.instr_rvalid_o, 0);
      chk("mid-rst rdata",  bus.instr_rdata_o, 0);
      chk("mid-rst state",  state, 0);
      chk("mid-rst fetch",  fc, 0);
      chk("mid-rst nop",    nc, 0);
      chk("mid-rst last",   last, 0);
      chk("mid-rst mis",    mis, 0);
      rst = 1'b0;
      set_in(1, 0, 0, 0, 0, 0);
      tick();
      set_in(1, 0, 0, 0, 1, 0);
      #1;
      chk("post-rst gnt", bus.instr_gnt_o, 1);
      tick();
      chk("post-rst fifo empty", bus.instr_rdata_o, NOP);
      chk("post-rst nop", nc, 1);
      set_in(0, 0, 0, 0, 0, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_stream_responder.md
INSTR_STREAM_RESPONDER -- requirements
Module: instr_stream_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning instruction FIFO depth (power of 2, 2..64).
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the word returned on starvation (addi x0,x0,0).
REQ-003 The block SHALL have parameter FILL_NOP, default 1, meaning 1 = return NOP_INSTR when empty, 0 = withhold grant when empty.
REQ-004 The block SHALL have one clock, clk_i, and a synchronous, active-high reset, rst_i.
REQ-005 Ports (name, direction, width, meaning):
- clk_i, in, 1, clock
- rst_i, in, 1, synchronous active-high reset
- en_i, in, 1, fetch service enable
- flush_i, in, 1, discard all FIFO contents
- push_valid_i, in, 1, testbench instruction push request
- push_data_i, in, 32, instruction word
- push_ready_o, out, 1, FIFO can accept a push
- instr_req_i, in, 1, core fetch request
- instr_addr_i, in, 32, core fetch address
- instr_gnt_o, out, 1, fetch grant
- instr_rvalid_o, out, 1, response valid
- instr_rdata_o, out, 32, response instruction
- state_o, out, 2, FSM state: IDLE=0, RUN=1, STARVED=2
- fetch_cnt_o, out, 16, granted fetches, wrapping
- nop_cnt_o, out, 16, NOPs returned, saturating at 16'hFFFF
- last_addr_o, out, 32, address of the last granted fetch
- misalign_o, out, 1, sticky: a granted address had addr[1:0] != 0

Function
REQ-006 The block SHALL assert push_ready_o when count < DEPTH; a push SHALL occur when push_valid_i && push_ready_o, with no same-cycle full bypass.
REQ-007 instr_gnt_o SHALL be combinational and equal to instr_req_i && (state == RUN) && (count > 0 || FILL_NOP), where count is the FIFO count at cycle start.
REQ-008 A grant SHALL pop the FIFO head when count > 0; otherwise the returned word SHALL be NOP_INSTR and nop_cnt_o SHALL increment, saturating.
REQ-009 instr_rvalid_o SHALL assert exactly one cycle after each grant, with the popped or NOP word registered on instr_rdata_o. Back-to-back grants SHALL produce back-to-back rvalid.
REQ-010 instr_rdata_o SHALL hold its last value while instr_rvalid_o is low.
REQ-011 Each grant SHALL register instr_addr_i into last_addr_o, increment fetch_cnt_o (wrapping 16'hFFFF -> 0), and set misalign_o when instr_addr_i[1:0] != 0.
REQ-012 FSM transitions:
- IDLE -> RUN when en_i = 1.
- RUN -> IDLE when en_i = 0.
- RUN -> STARVED when FILL_NOP = 0, count = 0 and instr_req_i = 1.
- STARVED -> RUN when count > 0.
- STARVED -> IDLE when en_i = 0.
- en_i = 0 SHALL take priority over all other transitions.
REQ-013 Push and pop in the same cycle SHALL leave count unchanged; a push into an empty FIFO SHALL NOT be granted or returned in that same cycle.
REQ-014 flush_i SHALL zero count and the read/write pointers at the next edge and SHALL override any same-cycle push. A same-cycle grant SHALL still return the word popped before the flush. An rvalid already pending SHALL still be delivered.
REQ-015 When en_i drops with a grant pending, the pending rvalid SHALL still be delivered the next cycle.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-017 While rst_i = 1 at an edge, the block SHALL set: state IDLE, count 0, pointers 0, instr_rvalid_o 0, instr_rdata_o 0, fetch_cnt_o 0, nop_cnt_o 0, last_addr_o 0, misalign_o 0.
REQ-018 instr_gnt_o SHALL be 0 while rst_i = 1.
REQ-019 Reset asserted mid-stream SHALL drop any pending rvalid and all FIFO contents.

Verification
REQ-020 Basic stream: reset; en_i=1; push 32'h00500093, 32'h00A00113; req held high, addr 0 then 4 -> gnt on 2 cycles, rvalid next cycles with those words in order; fetch_cnt_o=2; last_addr_o=4.
REQ-021 Starvation with FILL_NOP=1: empty FIFO; req for 3 cycles -> 3 grants, rdata 32'h00000013 each, nop_cnt_o=3.
REQ-022 Starvation with FILL_NOP=0: empty FIFO, req high -> gnt 0, state_o=2; push 32'h00000033 -> next cycle state RUN, gnt 1, then rvalid with 32'h00000033.
REQ-023 Full/wrap: push 8 words -> push_ready_o=0; push 9th is ignored; pop all 8 in order; push and pop 8 more -> correct order across pointer wrap.
REQ-024 Flush/misalign: push 3 words, flush_i with simultaneous push -> count 0; grant at addr 32'h00000002 -> NOP returned, misalign_o=1 and stays 1 through later aligned fetches.
REQ-025 Reset mid-operation: grant, then rst_i=1 in the following cycle -> instr_rvalid_o=0, all counters 0, state_o=0.
